// File: rtl/program_counter.sv
// program_counter
//   Program counter register for the single-cycle RISC-V core. Holds the address
//   of the instruction being fetched and loads the externally computed next PC
//   on every rising clock edge. There is no enable or stall.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous active-high reset; forces PC to RESET_VECTOR
//   NPC        in   next program counter, loaded at each rising edge out of reset
//   PC         out  current program counter (registered)
//   PC_plus4   out  PC + 4, combinational, wraps modulo 2^WIDTH
//   misaligned out  PC[1:0] != 0, combinational, informational only
module program_counter #(
   parameter int unsigned     WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] NPC,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_plus4,
   output logic             misaligned
);

   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_q;

   // NPC is stored verbatim: no masking or alignment, the core owns legality.
   always_comb begin
      pc_d = NPC;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      PC         = pc_q;
      // Carry out of the top bit is dropped, so 0xFFFFFFFC + 4 wraps to 0.
      PC_plus4   = pc_q + WIDTH'(4);
      misaligned = |pc_q[1:0];
   end

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] plus4;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] NPC;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic        misaligned;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   event chk_ev;

   program_counter #(
      .WIDTH       (32),
      .RESET_VECTOR(32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .NPC       (NPC),
      .PC        (PC),
      .PC_plus4  (PC_plus4),
      .misaligned(misaligned)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Queue an expected output set and ask the monitor to check it now.
   task automatic expect_out(input string name, input logic [31:0] pc,
                             input logic [31:0] plus4, input logic mis);
      exp_t e;
      e.name  = name;
      e.pc    = pc;
      e.plus4 = plus4;
      e.mis   = mis;
      exp_q.push_back(e);
      ->chk_ev;
      #1;
   endtask

   // Drive NPC, let one rising edge load it, then queue the expectation.
   task automatic step(input string name, input logic [31:0] npc,
                       input logic [31:0] pc, input logic [31:0] plus4, input logic mis);
      NPC = npc;
      @(posedge clk);
      #1;
      expect_out(name, pc, plus4, mis);
   endtask

   // Monitor: pops the scoreboard whenever the driver flags outputs as ready.
   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (PC !== e.pc || PC_plus4 !== e.plus4 || misaligned !== e.mis) begin
               n_fail++;
               $display("FAIL %s: got PC=%h PC_plus4=%h mis=%b, want PC=%h PC_plus4=%h mis=%b",
                        e.name, PC, PC_plus4, misaligned, e.pc, e.plus4, e.mis);
            end
         end
      end
   end

   // Outputs must never be X once reset has been seen.
   initial begin
      wait (rst === 1'b1);
      forever begin
         @(negedge clk);
         n_tests++;
         if ($isunknown({PC, PC_plus4, misaligned})) begin
            n_fail++;
            $display("FAIL x_check: got PC=%h PC_plus4=%h mis=%b, want no X bits",
                     PC, PC_plus4, misaligned);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      NPC = 32'h1234_5678;
      #1;
      expect_out("reset_async", 32'h0, 32'h4, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset_hold", 32'h0, 32'h4, 1'b0);

      rst = 1'b0;
      #1;
      expect_out("release_no_load", 32'h0, 32'h4, 1'b0);

      step("seq_4",  32'h4, 32'h4, 32'h8,  1'b0);
      step("seq_8",  32'h8, 32'h8, 32'hC,  1'b0);
      step("seq_c",  32'hC, 32'hC, 32'h10, 1'b0);
      step("wrap",   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0);

      step("load_pre_rst", 32'h1234_5678, 32'h1234_5678, 32'h1234_567C, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect_out("rst_mid_cycle", 32'h0, 32'h4, 1'b0);
      @(posedge clk);
      #1;
      expect_out("rst_over_edge", 32'h0, 32'h4, 1'b0);
      rst = 1'b0;
      #1;
      expect_out("rst_release", 32'h0, 32'h4, 1'b0);
      @(posedge clk);
      #1;
      expect_out("load_after_rst", 32'h1234_5678, 32'h1234_567C, 1'b0);

      step("zero",   32'h0, 32'h0, 32'h4, 1'b0);
      step("mis_6",  32'h6, 32'h6, 32'hA, 1'b1);
      step("mis_3",  32'h3, 32'h3, 32'h7, 1'b1);
      step("align_8", 32'h8, 32'h8, 32'hC, 1'b0);

      // Reset asserted right at a rising edge must win over the NPC load.
      NPC = 32'hDEAD_BEE0;
      @(posedge clk);
      rst = 1'b1;
      #1;
      expect_out("rst_at_edge", 32'h0, 32'h4, 1'b0);
      rst = 1'b0;
      step("final_load", 32'hDEAD_BEE0, 32'hDEAD_BEE0, 32'hDEAD_BEE4, 1'b0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
